s2_serial_loader: RTL

//  Parametrised serial-frame receiver: deserialises MSB-first {addr,data} frames on sd, framed by

---
 rtl/s2_serial_loader.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/s2_serial_loader.sv
// s2_serial_loader -- serial-frame receiver feeding an RB2-style register bank.
//
// Deserialises MSB-first {addr, data} frames on sd while sen is low and
// writes each completed word into the register bank for exactly one cycle.
// An early sen release aborts the frame. After NUM_WORDS successful writes
// the loader pulses done for one cycle and restarts its word count.
//
// Optional build macro:
//   PARITY_EN  - each frame carries one extra even-parity bit after the data.
//                A frame with bad parity is dropped and frame_err pulses.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   sen        frame enable, active low, sampled on every edge
//   sd         serial data, MSB first: addr, then data (then parity)
//   rb_rw      bank R/W strobe: 0 = write this cycle, 1 = idle
//   rb_a       bank address, valid while rb_rw=0, otherwise 0
//   rb_d       bank write data, valid while rb_rw=0, otherwise 0
//   busy       high while a frame is being received or written
//   frame_err  one-cycle pulse: frame aborted or parity failed
//   word_cnt   successful writes since the last done or reset
//   done       one-cycle pulse after the NUM_WORDS-th write
module s2_serial_loader #(
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 18,
  parameter int NUM_WORDS = 8,
  localparam int CNT_W    = $clog2(NUM_WORDS + 1),
  localparam int BIT_W    = $clog2(ADDR_W + DATA_W + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sen,
  input  logic              sd,
  output logic              rb_rw,
  output logic [ADDR_W-1:0] rb_a,
  output logic [DATA_W-1:0] rb_d,
  output logic              busy,
  output logic              frame_err,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              done
);

`ifdef PARITY_EN
  localparam int FRAME_LEN = ADDR_W + DATA_W + 1;
`else
  localparam int FRAME_LEN = ADDR_W + DATA_W;
`endif

  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WRITE,
    DONE
  } state_t;

  state_t               state;
  logic [FRAME_LEN-1:0] shreg;
  logic [BIT_W-1:0]     bit_cnt;

  // Frame as it will look once the current sd bit is shifted in.
  logic [FRAME_LEN-1:0] frame_next;
  logic [ADDR_W-1:0]    addr_field;
  logic [DATA_W-1:0]    data_field;
  logic                 frame_ok;

  always_comb begin
    frame_next = {shreg[FRAME_LEN-2:0], sd};
    addr_field = frame_next[FRAME_LEN-1 -: ADDR_W];
    data_field = frame_next[FRAME_LEN-1-ADDR_W -: DATA_W];
`ifdef PARITY_EN
    // Even parity across addr, data and the parity bit itself.
    frame_ok   = ~(^frame_next);
`else
    frame_ok   = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      rb_rw     <= 1'b1;
      rb_a      <= '0;
      rb_d      <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      word_cnt  <= '0;
      done      <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a branch below re-asserts them.
      rb_rw     <= 1'b1;
      rb_a      <= '0;
      rb_d      <= '0;
      frame_err <= 1'b0;
      done      <= 1'b0;

      unique case (state)
        IDLE: begin
          if (!sen) begin
            shreg   <= frame_next;
            bit_cnt <= BIT_W'(1);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          if (sen) begin
            frame_err <= 1'b1;
            bit_cnt   <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            shreg   <= frame_next;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              // A bad-parity frame still spends its WRITE cycle, but with
              // rb_rw held high so the bank is untouched.
              if (frame_ok) begin
                rb_rw <= 1'b0;
                rb_a  <= addr_field;
                rb_d  <= data_field;
              end else begin
                frame_err <= 1'b1;
              end
              state <= WRITE;
            end
          end
        end

        WRITE: begin
          bit_cnt <= '0;
          // rb_rw low here means the bank write really happened.
          if (!rb_rw && word_cnt == LAST_WORD) begin
            word_cnt <= word_cnt + 1'b1;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            if (!rb_rw) begin
              word_cnt <= word_cnt + 1'b1;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        DONE: begin
          word_cnt <= '0;
          busy     <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
